nrs_re_demapper: RTL

//  Resource-element demapper front end of the NB-IoT downlink channel estimator.
//  - Takes the per-subframe FFT output stream of one PRB.
//  - Extracts the 8 NRS pilots (OFDM symbols 5, 6, 12, 13) into two slot banks.
//  - Serves them to ch_est_cntrl_unit through the demap_ready / demap_read / col / nrs_index_addr handshake.
//  - Sits between the FFT/CP-removal stage and the channel-estimation multipliers.

---
 rtl/nb_iot_ch_est_pkg.sv | 36 +++
 rtl/nrs_slot_bank.sv | 54 +++++
 rtl/nrs_re_demapper.sv | 128 ++++++++++++
 3 files changed

// File: rtl/nb_iot_ch_est_pkg.sv
// Shared constants, serve-FSM encoding and pilot-position helpers for the
// NB-IoT channel-estimator front end.
package nb_iot_ch_est_pkg;

    localparam logic [3:0] NRS_SYM_S0A  = 4'd5;
    localparam logic [3:0] NRS_SYM_S0B  = 4'd6;
    localparam logic [3:0] NRS_SYM_S1A  = 4'd12;
    localparam logic [3:0] NRS_SYM_S1B  = 4'd13;
    localparam logic [2:0] NRS_PER_SLOT = 3'd4;
    localparam int         NUM_SC       = 12;
    localparam logic [3:0] V_SECOND     = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_SERVE = 2'd2
    } serve_state_t;

    // Lowest pilot subcarrier, (v_shift + v) mod 6; the second pilot sits 6 above.
    function automatic logic [3:0] pilot_base(input logic [2:0] v_shift, input logic second);
        logic [3:0] s;
        s = {1'b0, v_shift} + (second ? V_SECOND : 4'd0);
        if (s >= 4'd6) s = s - 4'd6;
        return s;
    endfunction

    function automatic logic is_nrs_sym(input logic [3:0] sym);
        return (sym == NRS_SYM_S0A) || (sym == NRS_SYM_S0B) ||
               (sym == NRS_SYM_S1A) || (sym == NRS_SYM_S1B);
    endfunction

    function automatic logic is_second_sym(input logic [3:0] sym);
        return (sym == NRS_SYM_S0B) || (sym == NRS_SYM_S1B);
    endfunction

endpackage

// File: rtl/nrs_slot_bank.sv
// Four-entry I/Q pilot store for one slot, with per-entry written bits so a
// repeated write to the same entry does not advance the fill count.
module nrs_slot_bank
    import nb_iot_ch_est_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_re,
    input  logic [DATA_W-1:0] wr_im,
    input  logic              clr,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_re,
    output logic [DATA_W-1:0] rd_im,
    output logic              full
);

    logic [DATA_W-1:0] re_q [4];
    logic [DATA_W-1:0] im_q [4];
    logic [3:0]        written;
    logic [2:0]        count;
    logic              wr_ok;

    assign full  = (count == NRS_PER_SLOT);
    assign wr_ok = wr_en && !full && !clr;
    assign rd_re = re_q[rd_addr];
    assign rd_im = im_q[rd_addr];

    // Fill tracking: clear wins over write, writes to a full bank are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            written <= 4'd0;
            count   <= 3'd0;
        end else if (clr) begin
            written <= 4'd0;
            count   <= 3'd0;
        end else if (wr_ok) begin
            written[wr_addr] <= 1'b1;
            if (!written[wr_addr]) count <= count + 3'd1;
        end
    end

    // Pilot payload storage; contents are only meaningful while written is set.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            re_q[wr_addr] <= wr_re;
            im_q[wr_addr] <= wr_im;
        end
    end

endmodule

// File: rtl/nrs_re_demapper.sv
// NRS resource-element demapper: picks the 8 pilots of a subframe out of the
// FFT stream into two slot banks and serves them one bank at a time.
module nrs_re_demapper
    import nb_iot_ch_est_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_SC = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [DATA_W-1:0] fft_re,
    input  logic [DATA_W-1:0] fft_im,
    input  logic [3:0]        fft_sym,
    input  logic [3:0]        fft_sc,
    input  logic [2:0]        v_shift,
    input  logic              demap_read,
    input  logic [3:0]        col,
    input  logic [1:0]        nrs_index_addr,
    output logic              demap_ready,
    output logic [DATA_W-1:0] nrs_re_out,
    output logic [DATA_W-1:0] nrs_im_out,
    output logic              nrs_out_valid,
    output logic              overflow_err,
    output logic              req_err
);

    serve_state_t      state, state_nxt;
    logic              serve_ptr;

    logic              second, wr_bank, vs_ok, hit_m0, hit_m1, cap, sym0;
    logic [3:0]        base;
    logic [1:0]        wr_addr;
    logic [1:0]        wr_en, clr, full;
    logic [DATA_W-1:0] bank_re [2];
    logic [DATA_W-1:0] bank_im [2];

    logic              rd_bank, col_ok, rd_req, rd_legal, rd_bad, release_now;

    // Capture decode: pilot test for the incoming RE.
    always_comb begin
        second  = is_second_sym(fft_sym);
        wr_bank = (fft_sym >= NRS_SYM_S1A);
        vs_ok   = (v_shift <= 3'd5);
        base    = pilot_base(v_shift, second);
        hit_m0  = (fft_sc == base);
        hit_m1  = (fft_sc == base + 4'd6);
        cap     = fft_valid && vs_ok && is_nrs_sym(fft_sym) && (int'(fft_sc) < NUM_SC)
                  && (hit_m0 || hit_m1);
        wr_addr = {second, hit_m1};
        sym0    = fft_valid && (fft_sym == 4'd0);
        wr_en   = {cap && wr_bank, cap && !wr_bank};
    end

    // Read request decode: a legal read targets the served bank with a matching half.
    always_comb begin
        rd_bank     = (col >= NRS_SYM_S1A);
        col_ok      = is_nrs_sym(col);
        rd_req      = demap_read && (state != ST_IDLE);
        rd_legal    = rd_req && col_ok && (rd_bank == serve_ptr)
                      && (nrs_index_addr[1] == is_second_sym(col));
        rd_bad      = rd_req && !rd_legal;
        release_now = rd_legal && (nrs_index_addr == 2'd3);
        clr[0]      = (sym0 && !full[0]) || (release_now && !serve_ptr);
        clr[1]      = (sym0 && !full[1]) || (release_now && serve_ptr);
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        nrs_slot_bank #(.DATA_W(DATA_W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[g]),
            .wr_addr (wr_addr),
            .wr_re   (fft_re),
            .wr_im   (fft_im),
            .clr     (clr[g]),
            .rd_addr (nrs_index_addr),
            .rd_re   (bank_re[g]),
            .rd_im   (bank_im[g]),
            .full    (full[g])
        );
    end

    // Serve FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Serve FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (full[serve_ptr]) state_nxt = ST_READY;
            ST_READY: if (release_now)     state_nxt = ST_IDLE;
                      else if (rd_legal)   state_nxt = ST_SERVE;
            ST_SERVE: if (release_now)     state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // Serve FSM outputs.
    always_comb begin
        demap_ready = (state == ST_READY) || (state == ST_SERVE);
    end

    // Read data path, serve pointer and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            serve_ptr     <= 1'b0;
            nrs_out_valid <= 1'b0;
            nrs_re_out    <= '0;
            nrs_im_out    <= '0;
            overflow_err  <= 1'b0;
            req_err       <= 1'b0;
        end else begin
            nrs_out_valid <= rd_legal;
            if (rd_legal) begin
                nrs_re_out <= bank_re[rd_bank];
                nrs_im_out <= bank_im[rd_bank];
            end
            if (release_now) serve_ptr <= ~serve_ptr;
            if (cap && full[wr_bank]) overflow_err <= 1'b1;
            if (rd_bad || (fft_valid && !vs_ok)) req_err <= 1'b1;
        end
    end

endmodule
